// File: rtl/opcode_pkg.sv
// Shared opcode constants, operation select encoding and decoder states.
// Also used by the keypad encoder so both sides agree on opcodes.
package opcode_pkg;

    localparam logic [2:0] OP_NONE = 3'b000;
    localparam logic [2:0] OP_ADD  = 3'b001;
    localparam logic [2:0] OP_SUB  = 3'b010;

    localparam logic [1:0] SEL_NONE = 2'b00;
    localparam logic [1:0] SEL_ADD  = 2'b01;
    localparam logic [1:0] SEL_SUB  = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_OP,
        S_WAIT_B,
        S_EXEC,
        S_SHOW
    } state_t;

    // Unknown opcodes map to SEL_NONE, which callers treat as invalid.
    function automatic logic [1:0] op_to_sel(input logic [2:0] op);
        logic [1:0] sel;
        case (op)
            OP_ADD:  sel = SEL_ADD;
            OP_SUB:  sel = SEL_SUB;
            default: sel = SEL_NONE;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/opcode_decoder_rise_detect.sv
// Rising-edge detector for one key level.
// A level already high when reset releases is not reported as a press.
module rise_detect (
    input  logic clk,
    input  logic rst,
    input  logic level,
    output logic rise
);

    logic prev;
    logic armed;

    always_ff @(posedge clk) begin
        if (rst) begin
            prev  <= 1'b0;
            armed <= 1'b0;
        end else begin
            prev  <= level;
            armed <= 1'b1;
        end
    end

    assign rise = armed & level & ~prev;

endmodule

// File: rtl/opcode_decoder.sv
// Keypad sequencer for the matrix ALU: A, operation, B, execute, show.
// All outputs are registered; strobes last exactly one cycle.
module opcode_decoder
    import opcode_pkg::*;
#(
    parameter int ALU_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] opcode,
    input  logic       is_op,
    input  logic       is_enter,
    input  logic       is_result,
    input  logic       alu_done,
    output logic [1:0] op_sel,
    output logic       load_a,
    output logic       load_b,
    output logic       alu_start,
    output logic       result_valid,
    output logic       busy,
    output logic       err
);

    localparam int CW = $clog2(ALU_TIMEOUT + 1);
    localparam logic [CW-1:0] LAST = CW'(ALU_TIMEOUT - 1);
    localparam logic [CW-1:0] CMAX = CW'(ALU_TIMEOUT);

    state_t        state;
    logic [CW-1:0] cnt;
    logic          op_p;
    logic          en_p;
    logic          res_p;
    logic [1:0]    sel;
    logic          sel_ok;

    rise_detect u_op  (.clk(clk), .rst(rst), .level(is_op),     .rise(op_p));
    rise_detect u_en  (.clk(clk), .rst(rst), .level(is_enter),  .rise(en_p));
    rise_detect u_res (.clk(clk), .rst(rst), .level(is_result), .rise(res_p));

    assign sel    = op_to_sel(opcode);
    assign sel_ok = (sel != SEL_NONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            op_sel       <= SEL_NONE;
            load_a       <= 1'b0;
            load_b       <= 1'b0;
            alu_start    <= 1'b0;
            result_valid <= 1'b0;
            busy         <= 1'b0;
            err          <= 1'b0;
            cnt          <= '0;
        end else begin
            load_a    <= 1'b0;
            load_b    <= 1'b0;
            alu_start <= 1'b0;
            err       <= 1'b0;
            // Ambiguous op+enter is rejected; EXEC ignores all keys.
            if (op_p && en_p && state != S_EXEC) begin
                err <= 1'b1;
            end else begin
                unique case (state)
                    S_IDLE: begin
                        if (en_p) begin
                            load_a <= 1'b1;
                            state  <= S_WAIT_OP;
                        end
                    end
                    S_WAIT_OP: begin
                        if (op_p) begin
                            if (sel_ok) begin
                                op_sel <= sel;
                                state  <= S_WAIT_B;
                            end else begin
                                err <= 1'b1;
                            end
                        end
                    end
                    S_WAIT_B: begin
                        if (en_p) begin
                            load_b    <= 1'b1;
                            alu_start <= 1'b1;
                            busy      <= 1'b1;
                            cnt       <= '0;
                            state     <= S_EXEC;
                        end
                    end
                    S_EXEC: begin
                        if (alu_done) begin
                            result_valid <= 1'b1;
                            busy         <= 1'b0;
                            state        <= S_SHOW;
                        end else if (cnt >= LAST) begin
                            err    <= 1'b1;
                            op_sel <= SEL_NONE;
                            busy   <= 1'b0;
                            state  <= S_IDLE;
                        end else if (cnt != CMAX) begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    S_SHOW: begin
                        if (en_p) begin
                            op_sel       <= SEL_NONE;
                            result_valid <= 1'b0;
                            state        <= S_IDLE;
                        end else if (op_p) begin
                            if (sel_ok) begin
                                op_sel       <= sel;
                                result_valid <= 1'b0;
                                state        <= S_WAIT_B;
                            end else begin
                                err <= 1'b1;
                            end
                        end else if (res_p) begin
                            result_valid <= 1'b1;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: doc/opcode_decoder.md
OPCODE_DECODER -- requirements
Module: opcode_decoder

Interface
REQ-001 SHALL have parameter ALU_TIMEOUT, default 16, the maximum cycles to wait for alu_done in EXEC.
REQ-002 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-004 SHALL have port opcode, input, 3, the encoded operation from the keypad encoder (3'b001 add, 3'b010 subtract).
REQ-005 SHALL have port is_op, input, 1, a level that is high while an operation key is held.
REQ-006 SHALL have port is_enter, input, 1, a level that is high while the enter key is held.
REQ-007 SHALL have port is_result, input, 1, a level that is high while a result-producing key is held; it requests a display refresh only.
REQ-008 SHALL have port alu_done, input, 1, a one-cycle completion pulse from the matrix ALU.
REQ-009 SHALL have port op_sel, output, 2, the latched operation: 2'b01 add, 2'b10 subtract, 2'b00 none.
REQ-010 SHALL have outputs load_a, load_b and alu_start, each 1 bit, each a one-cycle strobe.
REQ-011 SHALL have outputs result_valid and busy, each 1 bit, level; and err, output, 1, a one-cycle strobe.

Function
REQ-012 SHALL detect a key press as the rising edge of is_op, is_enter or is_result, comparing each against a registered copy of the previous cycle's value.
REQ-013 SHALL treat a held level as one press; no repeat strobes while the level stays high.
REQ-014 SHALL register all outputs: an edge sampled at clock edge N produces its strobe or state change in the cycle after edge N, lasting exactly one cycle for strobes.
REQ-015 SHALL implement states IDLE, WAIT_OP, WAIT_B, EXEC and SHOW.
REQ-016 In IDLE, an enter press SHALL pulse load_a and go to WAIT_OP.
REQ-017 In WAIT_OP, an op press with opcode 3'b001 or 3'b010 SHALL latch op_sel and go to WAIT_B.
REQ-018 In WAIT_B, an enter press SHALL pulse load_b and alu_start in the same cycle and go to EXEC.
REQ-019 In EXEC, alu_done SHALL go to SHOW with result_valid high.
REQ-020 EXEC SHALL reload its cycle counter to 0 on entry; if ALU_TIMEOUT cycles pass without alu_done, it SHALL pulse err, clear op_sel and go to IDLE.
REQ-021 In SHOW, an enter press SHALL clear op_sel and result_valid and go to IDLE.
REQ-022 In SHOW, a valid op press SHALL latch the new op_sel, clear result_valid and go to WAIT_B, chaining with the result as operand A without a load_a strobe.
REQ-023 In SHOW, an is_result press SHALL keep result_valid high and have no other effect.
REQ-024 An op press with any opcode other than 3'b001 or 3'b010, in WAIT_OP or SHOW, SHALL pulse err and leave state and op_sel unchanged.
REQ-025 Presses not listed for the current state SHALL be ignored without err; this includes an op press in IDLE or WAIT_B, and any press in EXEC.
REQ-026 Simultaneous is_op and is_enter presses in the same cycle SHALL pulse err and change nothing.
REQ-027 alu_done outside EXEC SHALL be ignored.
REQ-028 busy SHALL be high exactly while in EXEC.
REQ-029 The timeout counter SHALL be $clog2(ALU_TIMEOUT+1) bits wide and SHALL saturate, never wrap.

Reset
REQ-030 While rst is high at a clock edge: state IDLE; op_sel 2'b00; all strobes, result_valid and busy 0; edge registers and counter 0.
REQ-031 rst asserted mid-operation, including EXEC with alu_start already issued, SHALL abort with no err pulse.
REQ-032 A key level already high when rst releases SHALL NOT register as a press.

Structure
REQ-033 A shared package opcode_pkg SHALL hold the opcode constants (OP_NONE 3'b000, OP_ADD 3'b001, OP_SUB 3'b010), the op_sel encoding and the state enumeration; the encoder SHALL use the same package.
REQ-034 A single sub-module rise_detect SHALL be instantiated once per key level; all other logic SHALL be flat.

Verification
REQ-035 Full add sequence: enter, op 3'b001, enter, then alu_done 3 cycles later -> load_a, op_sel 2'b01, load_b with alu_start, busy for 4 cycles, result_valid high.
REQ-036 EXEC with alu_done never arriving and ALU_TIMEOUT=16 -> err in the 17th cycle after entering EXEC, state IDLE, op_sel 2'b00.
REQ-037 In WAIT_OP, op press with opcode 3'b011 -> single err, still WAIT_OP; a following 3'b010 press -> op_sel 2'b10.
REQ-038 In SHOW, op press 3'b010 -> result_valid low and state WAIT_B with no load_a strobe; next enter -> load_b plus alu_start.
REQ-039 is_enter held high for 10 cycles in IDLE -> exactly one load_a strobe.
REQ-040 rst for 1 cycle during EXEC, with is_enter held high through the reset -> all outputs 0, no strobe after release until is_enter falls and rises again.
